// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath sizes and writeback select encodings.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_MEM  = 2'd1,
    MTR_LINK = 2'd2,
    MTR_RS   = 2'd3
  } mtr_e;

  typedef enum logic [1:0] {
    RD_RT   = 2'd0,
    RD_RD   = 2'd1,
    RD_R31  = 2'd2,
    RD_EXPL = 2'd3
  } rdst_e;

  localparam logic [REG_AW-1:0] REG_RA = 5'd31;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: one synchronous write port, two combinational
// read ports, asynchronous active-low clear, r0 hard-wired to zero.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [W-1:0]  rdata1_c,
  output logic [W-1:0]  rdata2_c
);

  logic [W-1:0] regs_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_c = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_c = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// MIPS writeback stage: resolves destination/data, gates the commit, and serves
// the ID read ports with same-cycle write-through; counts committed writes.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   ALUResult_WB,
  input  logic [DATA_W-1:0]   ReadDataFromMem_WB,
  input  logic [DATA_W-1:0]   ReadData1_WB,
  input  logic [DATA_W-1:0]   NextInstruct_WB,
  input  logic [31:0]         Instruction_WB,
  input  logic [REG_AW-1:0]   WriteRegAddress_WB,
  input  logic [1:0]          MemtoReg_WB,
  input  logic [1:0]          RegDst_WB,
  input  logic                RegWrite_WB,
  input  logic                RegWriteSel_WB,
  input  logic                Zero_WB,
  input  logic [REG_AW-1:0]   ReadRegister1,
  input  logic [REG_AW-1:0]   ReadRegister2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                WBWriteEn,
  output logic [REG_AW-1:0]   WBWriteAddr,
  output logic [DATA_W-1:0]   WBWriteData,
  output logic [DATA_W-1:0]   CommitCount
);

  logic [REG_AW-1:0] dest_c;
  logic [DATA_W-1:0] data_c;
  logic              wen_c;
  logic [DATA_W-1:0] rf_rd1_c;
  logic [DATA_W-1:0] rf_rd2_c;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;
  logic              unused_instr;

  // Only the rt/rd fields of the instruction word matter here.
  assign unused_instr = ^{Instruction_WB[31:21], Instruction_WB[10:0]};

  always_comb begin
    dest_c = Instruction_WB[20:16];
    case (rdst_e'(RegDst_WB))
      RD_RT:   dest_c = Instruction_WB[20:16];
      RD_RD:   dest_c = Instruction_WB[15:11];
      RD_R31:  dest_c = REG_RA;
      RD_EXPL: dest_c = WriteRegAddress_WB;
      default: dest_c = Instruction_WB[20:16];
    endcase
  end

  // Link target is PC+8 of the jump; the carry out is dropped.
  always_comb begin
    data_c = ALUResult_WB;
    case (mtr_e'(MemtoReg_WB))
      MTR_ALU:  data_c = ALUResult_WB;
      MTR_MEM:  data_c = ReadDataFromMem_WB;
      MTR_LINK: data_c = NextInstruct_WB + DATA_W'(4);
      MTR_RS:   data_c = ReadData1_WB;
      default:  data_c = ALUResult_WB;
    endcase
  end

  assign wen_c = RegWrite_WB & (~RegWriteSel_WB | Zero_WB) & (dest_c != '0);

  regfile_2r1w #(
    .W (DATA_W),
    .N (NREGS),
    .AW(REG_AW)
  ) u_rf (
    .clk     (Clk),
    .rst_n   (Reset),
    .we_i    (wen_c),
    .waddr_i (dest_c),
    .wdata_i (data_c),
    .raddr1_i(ReadRegister1),
    .raddr2_i(ReadRegister2),
    .rdata1_c(rf_rd1_c),
    .rdata2_c(rf_rd2_c)
  );

  // Write-through so ID sees the value being committed this cycle.
  assign ReadData1 = ((ReadRegister1 != '0) && wen_c && (ReadRegister1 == dest_c))
                     ? data_c : rf_rd1_c;
  assign ReadData2 = ((ReadRegister2 != '0) && wen_c && (ReadRegister2 == dest_c))
                     ? data_c : rf_rd2_c;

  assign count_d = wen_c ? (count_q + DATA_W'(1)) : count_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign WBWriteEn   = wen_c;
  assign WBWriteAddr = dest_c;
  assign WBWriteData = data_c;
  assign CommitCount = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic
// compared every cycle against an array-based model of the register file.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResult_WB, ReadDataFromMem_WB, ReadData1_WB, NextInstruct_WB, Instruction_WB;
  logic [4:0]  WriteRegAddress_WB;
  logic [1:0]  MemtoReg_WB, RegDst_WB;
  logic        RegWrite_WB, RegWriteSel_WB, Zero_WB;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic        WBWriteEn;
  logic [4:0]  WBWriteAddr;
  logic [31:0] WBWriteData, CommitCount;

  wb_regfile dut (
    .Clk(Clk), .Reset(Reset),
    .ALUResult_WB(ALUResult_WB), .ReadDataFromMem_WB(ReadDataFromMem_WB),
    .ReadData1_WB(ReadData1_WB), .NextInstruct_WB(NextInstruct_WB),
    .Instruction_WB(Instruction_WB), .WriteRegAddress_WB(WriteRegAddress_WB),
    .MemtoReg_WB(MemtoReg_WB), .RegDst_WB(RegDst_WB),
    .RegWrite_WB(RegWrite_WB), .RegWriteSel_WB(RegWriteSel_WB), .Zero_WB(Zero_WB),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WBWriteEn(WBWriteEn), .WBWriteAddr(WBWriteAddr), .WBWriteData(WBWriteData),
    .CommitCount(CommitCount)
  );

  always #5 Clk = ~Clk;

  int          vectors = 0;
  int          errors  = 0;
  bit          chk_on  = 1'b0;
  logic [31:0] model [32];
  logic [31:0] mcount;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: table lookups straight from the encodings.
  function automatic logic [4:0] m_dest();
    logic [4:0] c [4];
    c[0] = Instruction_WB[20:16];
    c[1] = Instruction_WB[15:11];
    c[2] = 5'd31;
    c[3] = WriteRegAddress_WB;
    return c[RegDst_WB];
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] c [4];
    c[0] = ALUResult_WB;
    c[1] = ReadDataFromMem_WB;
    c[2] = NextInstruct_WB + 32'd4;
    c[3] = ReadData1_WB;
    return c[MemtoReg_WB];
  endfunction

  function automatic logic m_en();
    return RegWrite_WB && (!RegWriteSel_WB || Zero_WB) && (m_dest() != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_en() && (a == m_dest())) return m_data();
    return model[a];
  endfunction

  always @(posedge Clk) begin
    if (Reset === 1'b1 && m_en()) begin
      model[m_dest()] = m_data();
      mcount = mcount + 32'd1;
    end
  end

  always @(negedge Reset) begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    mcount = 32'd0;
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      cmp("wb_en",   {31'd0, WBWriteEn}, {31'd0, m_en()});
      cmp("wb_addr", {27'd0, WBWriteAddr}, {27'd0, m_dest()});
      cmp("wb_data", WBWriteData, m_data());
      cmp("rd1",     ReadData1, m_read(ReadRegister1));
      cmp("rd2",     ReadData2, m_read(ReadRegister2));
      cmp("count",   CommitCount, mcount);
    end
  end

  task automatic wr(input logic [1:0] mtr, input logic [1:0] rdst, input logic sel,
                    input logic z, input logic [4:0] rd, input logic [31:0] alu,
                    input logic [31:0] npc);
    MemtoReg_WB        = mtr;
    RegDst_WB          = rdst;
    RegWrite_WB        = 1'b1;
    RegWriteSel_WB     = sel;
    Zero_WB            = z;
    Instruction_WB     = {6'h00, 5'd1, 5'd3, rd, 11'h020};
    WriteRegAddress_WB = 5'd4;
    ALUResult_WB       = alu;
    ReadDataFromMem_WB = 32'h22;
    ReadData1_WB       = 32'h33;
    NextInstruct_WB    = npc;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_WB = 1'b0;
    #1;
  endtask

  task automatic rand_cycle();
    logic [4:0] d;
    MemtoReg_WB        = 2'($urandom_range(0, 3));
    RegDst_WB          = 2'($urandom_range(0, 3));
    RegWrite_WB        = ($urandom_range(0, 3) != 0);
    RegWriteSel_WB     = ($urandom_range(0, 2) == 0);
    Zero_WB            = 1'($urandom);
    Instruction_WB     = $urandom;
    Instruction_WB[20:16] = 5'($urandom_range(0, 9));
    Instruction_WB[15:11] = 5'($urandom_range(0, 9));
    WriteRegAddress_WB = 5'($urandom);
    ALUResult_WB       = $urandom;
    ReadDataFromMem_WB = $urandom;
    ReadData1_WB       = $urandom;
    NextInstruct_WB    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
    d = m_dest();
    ReadRegister1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 11));
    ReadRegister2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
    step();
  endtask

  logic [31:0] exp_mtr [4];

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    mcount = 32'd0;
    Reset = 1'b0;
    wr(2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    RegWrite_WB   = 1'b0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd31;
    chk_on = 1'b1;
    #2;
    cmp("reset_count", CommitCount, 32'd0);
    cmp("reset_rd1",   ReadData1, 32'd0);
    cmp("reset_rd2",   ReadData2, 32'd0);
    #10;
    Reset = 1'b1;
    step();

    // Every writeback data source into r5 via rd.
    exp_mtr[0] = 32'h11; exp_mtr[1] = 32'h22; exp_mtr[2] = 32'h404; exp_mtr[3] = 32'h33;
    for (int k = 0; k < 4; k++) begin
      wr(2'(k), 2'd1, 1'b0, 1'b0, 5'd5, 32'h11, 32'h400);
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd0;
      #1;
      cmp("mtr_bypass", ReadData1, exp_mtr[k]);
      step();
      idle();
      cmp("mtr_r5", ReadData1, exp_mtr[k]);
    end
    cmp("mtr_count", CommitCount, 32'd4);

    // Link to r31 wraps to zero; seed r31 first so the wrap is observable.
    wr(2'd0, 2'd2, 1'b0, 1'b0, 5'd0, 32'hCAFE, 32'd0);
    ReadRegister1 = 5'd31;
    step();
    idle();
    cmp("r31_seed", ReadData1, 32'hCAFE);
    wr(2'd2, 2'd2, 1'b0, 1'b0, 5'd0, 32'd0, 32'hFFFFFFFC);
    step();
    idle();
    cmp("r31_wrap",  ReadData1, 32'd0);
    cmp("r31_count", CommitCount, 32'd6);

    // Conditional write: blocked when Zero is low, committed when high.
    wr(2'd0, 2'd1, 1'b1, 1'b0, 5'd7, 32'hAA, 32'd0);
    ReadRegister1 = 5'd7;
    #1;
    cmp("cond0_en", {31'd0, WBWriteEn}, 32'd0);
    step();
    idle();
    cmp("cond0_r7",    ReadData1, 32'd0);
    cmp("cond0_count", CommitCount, 32'd6);
    wr(2'd0, 2'd1, 1'b1, 1'b1, 5'd7, 32'hAA, 32'd0);
    step();
    idle();
    cmp("cond1_r7",    ReadData1, 32'hAA);
    cmp("cond1_count", CommitCount, 32'd7);

    // r0 write is dropped.
    wr(2'd0, 2'd1, 1'b0, 1'b0, 5'd0, 32'hDEAD, 32'd0);
    ReadRegister1 = 5'd0;
    #1;
    cmp("r0_en",  {31'd0, WBWriteEn}, 32'd0);
    cmp("r0_rd1", ReadData1, 32'd0);
    step();
    idle();
    cmp("r0_after", ReadData1, 32'd0);
    cmp("r0_count", CommitCount, 32'd7);

    // Both ports bypass the same write.
    wr(2'd0, 2'd1, 1'b0, 1'b0, 5'd9, 32'h1234, 32'd0);
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd9;
    #1;
    cmp("byp_rd1_pre", ReadData1, 32'h1234);
    cmp("byp_rd2_pre", ReadData2, 32'h1234);
    step();
    idle();
    cmp("byp_rd1_post", ReadData1, 32'h1234);
    cmp("byp_rd2_post", ReadData2, 32'h1234);
    cmp("byp_count",    CommitCount, 32'd8);

    for (int n = 0; n < 500; n++) rand_cycle();

    // Mid-run asynchronous reset, checked between edges.
    RegWrite_WB = 1'b0;
    #2;
    Reset = 1'b0;
    #0.5;
    cmp("areset_count", CommitCount, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(31 - a);
      #0.2;
      cmp("areset_rd1", ReadData1, 32'd0);
      cmp("areset_rd2", ReadData2, 32'd0);
    end
    wr(2'd0, 2'd1, 1'b0, 1'b0, 5'd12, 32'h5A5A, 32'd0);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    step();
    step();
    RegWrite_WB = 1'b0;
    Reset = 1'b1;
    #1;
    cmp("held_count", CommitCount, 32'd0);
    wr(2'd0, 2'd1, 1'b0, 1'b0, 5'd12, 32'h5A5A, 32'd0);
    ReadRegister1 = 5'd12;
    step();
    idle();
    cmp("post_reset_r12",   ReadData1, 32'h5A5A);
    cmp("post_reset_count", CommitCount, 32'd1);

    for (int n = 0; n < 200; n++) rand_cycle();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
